// File: rtl/spi_sched.sv
// Sequencer/arbiter sharing one SPI master between host write, host read and a periodic poll read.
// Latency: request -> strobe 1 cycle, completion -> ack 1 cycle; requests are held until acked, one command in flight.
module spi_sched #(
    parameter int DW          = 20,
    parameter int POLL_PERIOD = 100000,
    parameter int TIMEOUT     = 65535
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          rd_req,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    input  logic          poll_en,
    output logic          sample_valid,
    output logic          spi_we,
    output logic          spi_rd,
    output logic [DW-1:0] spi_data,
    input  logic          spi_insert,
    input  logic          spi_read_end,
    input  logic [DW-1:0] spi_rx,
    output logic          busy,
    input  logic          clr_err,
    output logic          timeout_err
);

    localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_DONE
    } state_t;

    state_t          r_state;
    logic [PCW-1:0]  r_poll_cnt;
    logic            r_poll_pending;
    logic [TCW-1:0]  r_to_cnt;
    logic            r_last_rd;
    logic            r_srv_rd;
    logic            r_srv_poll;
    logic            r_wr_ack;
    logic            r_rd_ack;
    logic            r_sample_valid;
    logic            r_spi_we;
    logic            r_spi_rd;
    logic            r_busy;
    logic            r_timeout_err;
    logic [DW-1:0]   r_spi_data;
    logic [DW-1:0]   r_rd_data;

    logic w_rd_dem;
    logic w_wr_win;
    logic w_to_hit;
    logic w_poll_wrap;
    logic w_poll_held;
    logic w_poll_done;

    assign w_rd_dem    = rd_req | r_poll_pending;
    // Write wins when alone, or on contention when read was served last.
    assign w_wr_win    = wr_req & (~w_rd_dem | r_last_rd);
    assign w_to_hit    = (r_to_cnt == TCW'(TIMEOUT - 1));
    assign w_poll_wrap = (r_poll_cnt == PCW'(POLL_PERIOD - 1));
    assign w_poll_held = r_srv_poll & (r_state != S_IDLE);
    assign w_poll_done = r_srv_poll & (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_to_cnt       <= '0;
            r_last_rd      <= 1'b1;
            r_srv_rd       <= 1'b0;
            r_srv_poll     <= 1'b0;
            r_wr_ack       <= 1'b0;
            r_rd_ack       <= 1'b0;
            r_sample_valid <= 1'b0;
            r_spi_we       <= 1'b0;
            r_spi_rd       <= 1'b0;
            r_busy         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_spi_data     <= '0;
            r_rd_data      <= '0;
        end else begin
            r_spi_we       <= 1'b0;
            r_spi_rd       <= 1'b0;
            r_wr_ack       <= 1'b0;
            r_rd_ack       <= 1'b0;
            r_sample_valid <= 1'b0;
            if (clr_err) r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wr_win) begin
                        r_spi_data <= wr_data;
                        r_last_rd  <= 1'b0;
                        r_spi_we   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_WR_ISSUE;
                    end else if (w_rd_dem) begin
                        r_srv_rd   <= rd_req;
                        r_srv_poll <= r_poll_pending;
                        r_last_rd  <= 1'b1;
                        r_spi_rd   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_RD_ISSUE;
                    end
                end
                S_WR_ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= S_WR_WAIT;
                end
                S_RD_ISSUE: begin
                    r_to_cnt <= '0;
                    r_state  <= S_RD_WAIT;
                end
                S_WR_WAIT: begin
                    if (spi_insert || w_to_hit) begin
                        r_wr_ack <= 1'b1;
                        r_state  <= S_DONE;
                        if (!spi_insert) r_timeout_err <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TCW'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (spi_read_end) begin
                        r_rd_data      <= spi_rx;
                        r_rd_ack       <= r_srv_rd;
                        r_sample_valid <= r_srv_poll;
                        r_state        <= S_DONE;
                    end else if (w_to_hit) begin
                        // Requester still gets its ack so it can release; the sample is dropped.
                        r_rd_ack      <= r_srv_rd;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TCW'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A granted poll survives poll_en dropping; only DONE retires it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_poll_cnt     <= '0;
            r_poll_pending <= 1'b0;
        end else begin
            if (!poll_en)
                r_poll_cnt <= '0;
            else if (w_poll_wrap)
                r_poll_cnt <= '0;
            else
                r_poll_cnt <= r_poll_cnt + PCW'(1);

            if (w_poll_done || (!poll_en && !w_poll_held))
                r_poll_pending <= 1'b0;
            else if (poll_en && w_poll_wrap)
                r_poll_pending <= 1'b1;
        end
    end

    assign wr_ack       = r_wr_ack;
    assign rd_ack       = r_rd_ack;
    assign rd_data      = r_rd_data;
    assign sample_valid = r_sample_valid;
    assign spi_we       = r_spi_we;
    assign spi_rd       = r_spi_rd;
    assign spi_data     = r_spi_data;
    assign busy         = r_busy;
    assign timeout_err  = r_timeout_err;

endmodule
